// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit for the execute stage.
// Produces a 2*WIDTH-bit product or quotient/remainder into hi/lo.
// Each operation takes one latch cycle, WIDTH iterations and one fix-up cycle.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   start        request pulse, only sampled while idle
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b         multiplicand/dividend, multiplier/divisor
//   busy         high while an operation is in flight
//   done         one-cycle pulse when hi/lo are written
//   hi, lo       product upper/lower half, or remainder/quotient
//   div_by_zero  raised with done for a divide by zero

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;      // product / quotient must be negated
    logic             neg_r;      // remainder must be negated (dividend negative)
    logic [WIDTH-1:0] a_r;        // raw dividend, returned as hi on divide by zero
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_hi;     // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier bits / dividend bits shifting into quotient
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r, dbz_r;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // ---------------- state register / next state ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath arithmetic ----------------
    always_comb begin
        a_abs = (op[0] && a[WIDTH-1]) ? -a : a;
        b_abs = (op[0] && b[WIDTH-1]) ? -b : b;

        // shift-add: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);

        // restoring division: bring in the next dividend bit, try subtract;
        // the extra top bit of div_diff is the borrow
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
        div_ge    = ~div_diff[WIDTH+1];

        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod : prod;
        q_fix    = neg_q ? -acc_lo : acc_lo;
        r_fix    = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_r    <= '0;
            b_mag  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    is_div <= op[1];
                    neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r  <= op[0] & a[WIDTH-1];
                    a_r    <= a;
                    b_mag  <= b_abs;
                    acc_hi <= '0;
                    acc_lo <= a_abs;
                    dbz_r  <= 1'b0;
                    cnt    <= CW'(WIDTH);
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (!is_div) begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end else begin
                        acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end
                end
                FIN: begin
                    done_r <= 1'b1;
                    if (!is_div) begin
                        {hi_r, lo_r} <= prod_fix;
                    end else if (b_mag == '0) begin
                        hi_r  <= a_r;
                        lo_r  <= '1;
                        dbz_r <= 1'b1;
                    end else begin
                        // most-negative / -1 falls out naturally: the quotient
                        // magnitude 2^(W-1) negates back to itself
                        hi_r <= r_fix;
                        lo_r <= q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a cycle-level reference model built
// from plain 64-bit arithmetic, a per-cycle compare process, directed cases
// with literal expectations, and randomized traffic.

module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // returns {div_by_zero, hi, lo}
    function automatic logic [2*W:0] ref_op(input logic [1:0] o,
                                            input logic [W-1:0] x, y);
        longint          sx, sy, q, r;
        logic [2*W-1:0]  p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin
                p = {32'b0, x} * {32'b0, y};
                return {1'b0, p};
            end
            2'd1: begin
                q = sx * sy;
                p = q;
                return {1'b0, p};
            end
            2'd2: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
        endcase
    endfunction

    // cycle model: a countdown of remaining busy cycles, results applied at the end
    int             m_rem  = 0;
    logic           m_done = 1'b0;
    logic           m_dz   = 1'b0;
    logic [W-1:0]   m_hi   = '0;
    logic [W-1:0]   m_lo   = '0;
    logic [2*W:0]   m_pend = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem <= 0; m_done <= 1'b0; m_dz <= 1'b0; m_hi <= '0; m_lo <= '0;
        end else if (m_rem == 0 && start) begin
            m_pend <= ref_op(op, a, b);
            m_rem  <= W + 1;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                {m_dz, m_hi, m_lo} <= m_pend;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_rem > 0));
            check("done", 64'(done), 64'(m_done));
            check("hi",   64'(hi),   64'(m_hi));
            check("lo",   64'(lo),   64'(m_lo));
            check("dz",   64'(div_by_zero), 64'(m_dz));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        // operands must be held internally, so scramble the inputs
        op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // waits for the model's done; returns busy cycles seen and done pulses seen
    task automatic wait_done(input bit noise, output int bc, output int dc);
        int n;
        n = 0; bc = 0; dc = 0;
        while (!m_done && n < 100) begin
            if (busy) bc++;
            if (done) dc++;
            start = noise && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (done) dc++;
        if (n >= 100) check("timeout", 64'(n), 64'(0));
    endtask

    task automatic run_lit(input string name, input logic [1:0] o,
                           input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        int bc, dc;
        issue(o, x, y);
        wait_done(1'b0, bc, dc);
        check({name, "_hi"}, 64'(hi), 64'(ehi));
        check({name, "_lo"}, 64'(lo), 64'(elo));
        check({name, "_dz"}, 64'(div_by_zero), 64'(edz));
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busycyc"}, 64'(bc), 64'd33);
    endtask

    initial begin
        int bc, dc, sel;
        logic [1:0]   o;
        logic [W-1:0] x, y;

        rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;

        // model pinned to hand-computed values
        check("ref_mult", 64'(ref_op(2'd1, 32'hFFFF_FFFD, 32'd7)), 64'hFFFF_FFFF_FFFF_FFEB);
        check("ref_div",  64'(ref_op(2'd3, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF_FFFF_FFFD);
        check("ref_ovf",  64'(ref_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF)), 64'h0000_0000_8000_0000);
        check("ref_dz",   65'(ref_op(2'd2, 32'd100, 32'd0)) >> 64, 64'd1);

        @(posedge clk); chk_en = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", 64'({hi, lo}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed cases
        run_lit("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_lit("mult_neg",  2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_lit("div_neg",   2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_lit("divu",      2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_lit("divu_zero", 2'd2, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        // back-to-back: issued in the done cycle; flag clears at accept
        issue(2'd0, 32'd3, 32'd4);
        check("dz_cleared", 64'(div_by_zero), 64'd0);
        wait_done(1'b0, bc, dc);
        check("b2b_lo", 64'({hi, lo}), 64'd12);
        check("b2b_busycyc", 64'(bc), 64'd33);

        // overflow with an ignored start mid-run
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, bc, dc);
        repeat (3) begin
            @(negedge clk);
            if (done) dc++;
        end
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        check("ovf_hi", 64'(hi), 64'd0);
        check("ovf_dz", 64'(div_by_zero), 64'd0);
        check("ovf_donecnt", 64'(dc), 64'd1);

        // reset during RUN aborts
        issue(2'd0, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", 64'({hi, lo}), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        run_lit("after_rst", 2'd0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom; y = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = '0;
            else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (sel == 2) y = 32'($urandom_range(1, 20));
            else if (sel == 3) y = -32'($urandom_range(1, 20));
            issue(o, x, y);
            wait_done(1'b1, bc, dc);
            check("rnd_busycyc", 64'(bc), 64'd33);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
